// File: rtl/dct_row_sequencer.sv
// Row sequencer for an 8x8 DCT engine: drives loads, compute wait,
// output latch and write-back for eight rows of one 64-word block.
module dct_row_sequencer #(
  parameter int COMPUTE_CYC = 4
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       start,
  input  logic       abort,
  output logic       clrReg,
  output logic [7:0] ldPIPOIn,
  output logic       loadOutReg,
  output logic [7:0] out_sel,
  output logic       addr_sel,
  output logic [5:0] rd_addr,
  output logic [5:0] wr_addr,
  output logic       mem_we,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLR     = 3'd1,
    LOAD    = 3'd2,
    COMPUTE = 3'd3,
    LATCH   = 3'd4,
    STORE   = 3'd5,
    DONE    = 3'd6
  } state_t;

  localparam logic [3:0] CLAST = 4'(COMPUTE_CYC - 1);

  state_t     state, state_d;
  logic [3:0] cnt, cnt_d;
  logic [2:0] row, row_d;
  logic [5:0] rd_q, wr_q;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state <= IDLE;
      cnt   <= '0;
      row   <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      row   <= row_d;
      rd_q  <= rd_addr;
      wr_q  <= wr_addr;
    end
  end

  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    row_d      = row;
    clrReg     = 1'b0;
    ldPIPOIn   = '0;
    loadOutReg = 1'b0;
    out_sel    = '0;
    addr_sel   = 1'b0;
    mem_we     = 1'b0;
    done       = 1'b0;
    rd_addr    = rd_q;
    wr_addr    = wr_q;
    busy       = (state != IDLE) && (state != DONE);

    unique case (state)
      IDLE: begin
        if (start && !abort) begin
          state_d = CLR;
          row_d   = '0;
          cnt_d   = '0;
        end
      end
      CLR: begin
        clrReg  = 1'b1;
        state_d = LOAD;
        cnt_d   = '0;
      end
      LOAD: begin
        if (!cnt[3])
          rd_addr = {row, cnt[2:0]};
        // register strobe trails the read by one cycle (memory latency)
        if (cnt != 4'd0)
          ldPIPOIn = 8'(1) << (cnt[2:0] - 3'd1);
        if (cnt == 4'd8) begin
          state_d = COMPUTE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + 4'd1;
        end
      end
      COMPUTE: begin
        if (cnt == CLAST) begin
          state_d = LATCH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + 4'd1;
        end
      end
      LATCH: begin
        loadOutReg = 1'b1;
        state_d    = STORE;
        cnt_d      = '0;
      end
      STORE: begin
        out_sel  = 8'(1) << cnt[2:0];
        addr_sel = 1'b1;
        mem_we   = 1'b1;
        wr_addr  = {row, cnt[2:0]};
        if (cnt == 4'd7) begin
          cnt_d = '0;
          if (row == 3'd7) begin
            state_d = DONE;
          end else begin
            row_d   = row + 3'd1;
            state_d = CLR;
          end
        end else begin
          cnt_d = cnt + 4'd1;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (abort && busy) begin
      state_d = IDLE;
      row_d   = '0;
      cnt_d   = '0;
    end
  end

endmodule
